// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction fetch front end. Keeps a word-address fetch pointer
//            and issues one instruction-memory read at a time over a
//            request/grant/response handshake. Each returned word is pushed,
//            tagged with its word address, into a small FIFO that decode
//            drains with valid/ready. A redirect reloads the pointer and
//            flushes both the buffered and the in-flight fetches.
// Ports    : clk            - clock, all state on the rising edge
//            rst            - asynchronous active-low reset
//            redirect_valid - load redirect_addr into the pointer and flush
//            redirect_addr  - new fetch word address
//            mem_req        - read request (high exactly in REQ)
//            mem_addr       - word address of the request
//            mem_gnt        - request accepted this cycle
//            mem_rvalid     - read data valid
//            mem_rdata      - read data
//            out_valid      - FIFO head valid
//            out_instr      - head instruction
//            out_pc         - head word address
//            out_ready      - decode accepts the head
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int                ADDR_W     = 30,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_W-1:0]    r_fetch_pc;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_cnt_w-1:0]   w_count_nxt;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [DATA_W-1:0]    r_instr_mem [DEPTH];
  logic [ADDR_W-1:0]    r_pc_mem    [DEPTH];

  logic w_push;
  logic w_pop;
  logic w_room;

  // A response landing in the same cycle as a redirect belongs to the old
  // instruction stream, so it is never pushed.
  assign w_push      = (r_state == ST_WAIT) && mem_rvalid && !redirect_valid;
  assign w_pop       = out_valid && out_ready;
  assign w_room      = (r_count < c_depth);
  assign w_count_nxt = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

  assign mem_req   = (r_state == ST_REQ);
  assign mem_addr  = r_fetch_pc;
  assign out_valid = (r_count != '0);
  assign out_instr = r_instr_mem[r_rd_ptr];
  assign out_pc    = r_pc_mem[r_rd_ptr];

  // Next-state logic. DROP exists because a granted request always returns
  // exactly one response; after a flush that response must be swallowed
  // before a new request may be issued.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!redirect_valid && w_room) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect_valid) begin
          w_state_nxt = mem_gnt ? ST_DROP : ST_IDLE;
        end else if (mem_gnt) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          w_state_nxt = mem_rvalid ? ST_IDLE : ST_DROP;
        end else if (mem_rvalid) begin
          // Decide on the occupancy after this cycle's push and pop so a
          // full FIFO parks in IDLE instead of issuing a request.
          w_state_nxt = (w_count_nxt < c_depth) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (mem_rvalid) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_ADDR;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_addr;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_push) begin
          r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
          r_wr_ptr   <= r_wr_ptr + c_ptr_w'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        end
        r_count <= w_count_nxt;
      end
    end
  end

  // Storage needs no reset: entries are only visible once r_count covers them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= mem_rdata;
      r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(w_push && (r_count == c_depth)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Self-checking bench for fetch_queue. A queue-based model of the
//            fetch stream is compared with the DUT outputs every cycle, with
//            directed scenarios pinned by literal expectations followed by a
//            randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int             AW       = 30;
  localparam int             DW       = 32;
  localparam int             DEPTH    = 4;
  localparam logic [AW-1:0]  RST_ADDR = '0;
  localparam logic [DW-1:0]  TAG      = 32'hA5A5_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          out_valid;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          out_ready = 1'b0;

  fetch_queue #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_ADDR(RST_ADDR)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } ent_t;

  int checks   = 0;
  int failures = 0;

  // Reference model: buffered words, fetch pointer, whether a request is
  // being presented, whether one is in flight and whether it is stale.
  ent_t          mq[$];
  logic [AW-1:0] m_pc;
  bit            m_req, m_out, m_stale;

  // Memory responder and logs.
  bit            pend;
  int            lat;
  logic [AW-1:0] pend_addr;
  logic [AW-1:0] req_log[$];
  logic [AW-1:0] pop_log[$];
  int            gnt_prob = 100, ready_prob = 100, lat_min = 1, lat_max = 1;
  bit            stray = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] req_at(input int i);
    return (req_log.size() > i) ? req_log[i] : '1;
  endfunction

  function automatic logic [AW-1:0] pop_at(input int i);
    return (pop_log.size() > i) ? pop_log[i] : '1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc    = RST_ADDR;
    m_req   = 0;
    m_out   = 0;
    m_stale = 0;
  endtask

  task automatic model_step();
    bit   pop, granted, resp;
    int   pre;
    ent_t e;
    pop     = (mq.size() != 0) && out_ready;
    granted = m_req && mem_gnt;
    resp    = m_out && mem_rvalid;
    pre     = mq.size();
    if (redirect_valid) begin
      mq.delete();
      m_pc = redirect_addr;
      if (granted) begin
        m_out = 1; m_stale = 1;
      end else if (m_out && !resp) begin
        m_stale = 1;
      end else begin
        m_out = 0; m_stale = 0;
      end
      m_req = 0;
    end else begin
      if (pop) begin
        pop_log.push_back(mq[0].pc);
        void'(mq.pop_front());
      end
      if (resp) begin
        if (!m_stale) begin
          e.pc = m_pc; e.instr = mem_rdata;
          mq.push_back(e);
          m_pc  = m_pc + 1'b1;
          m_req = (mq.size() < DEPTH);
        end else begin
          m_req = 0;
        end
        m_out = 0; m_stale = 0;
      end else if (granted) begin
        m_out = 1; m_stale = 0; m_req = 0;
      end else if (!m_out && !m_req) begin
        m_req = (pre < DEPTH);
      end
    end
  endtask

  task automatic compare_outputs();
    chk("mem_req", mem_req, m_req);
    if (m_req) chk("mem_addr", mem_addr, m_pc);
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_instr", out_instr, mq[0].instr);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input bit redir = 0, input logic [AW-1:0] raddr = '0);
    bit            commit, respond;
    logic [AW-1:0] caddr;
    compare_outputs();
    redirect_valid = redir;
    redirect_addr  = raddr;
    mem_gnt        = ($urandom_range(99) < gnt_prob);
    out_ready      = ($urandom_range(99) < ready_prob);
    respond        = pend && (lat == 0);
    mem_rvalid     = respond || stray;
    stray          = 0;
    mem_rdata      = respond ? (32'(pend_addr) ^ TAG) : $urandom();
    commit         = mem_req && mem_gnt;
    caddr          = mem_addr;
    @(posedge clk);
    model_step();
    if (respond) pend = 0;
    else if (pend) lat--;
    if (commit) begin
      pend      = 1;
      pend_addr = caddr;
      lat       = int'($urandom_range(lat_max, lat_min)) - 1;
      req_log.push_back(caddr);
    end
    @(negedge clk);
    redirect_valid = 0;
  endtask

  task automatic do_reset();
    #2;
    rst = 0; mem_gnt = 0; mem_rvalid = 0; redirect_valid = 0; out_ready = 0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_out_valid", out_valid, 0);
    model_reset();
    pend = 0;
    req_log.delete();
    pop_log.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic run_until_reqs(input string name, input int n);
    for (int k = 0; k < 60 && req_log.size() < n; k++) cycle();
    chk(name, req_log.size() >= n, 1);
  endtask

  task automatic run_until_req(input string name);
    for (int k = 0; k < 30 && !mem_req; k++) cycle();
    chk(name, mem_req, 1);
  endtask

  initial begin
    logic [AW-1:0] ra;
    @(negedge clk);
    do_reset();

    // Streaming with a 1-cycle memory and decode always ready.
    gnt_prob = 100; ready_prob = 100; lat_min = 1; lat_max = 1;
    cycle();
    chk("t1_first_req", mem_req, 1);
    chk("t1_first_addr", mem_addr, 0);
    cycle();
    chk("t1_valid_after_grant", out_valid, 0);
    cycle();
    chk("t1_valid_rise", out_valid, 1);
    chk("t1_head_pc", out_pc, 0);
    chk("t1_head_instr", out_instr, TAG);
    repeat (20) cycle();
    for (int i = 0; i < 6; i++) chk("t1_req_seq", req_at(i), i);
    for (int i = 0; i < 6; i++) chk("t1_pop_seq", pop_at(i), i);
    chk("t1_pops_rate", pop_log.size() >= 10 && pop_log.size() <= 12, 1);

    // Backpressure: FIFO fills, then one pop allows exactly one refill.
    do_reset();
    ready_prob = 0;
    repeat (16) cycle();
    chk("t2_req_count_full", req_log.size(), 4);
    chk("t2_idle_req", mem_req, 0);
    chk("t2_head_pc", out_pc, 0);
    ready_prob = 100;
    cycle();
    ready_prob = 0;
    repeat (8) cycle();
    chk("t2_req_count_refill", req_log.size(), 5);
    chk("t2_refill_addr", req_at(4), 4);
    chk("t2_head_after_pop", out_pc, 1);
    chk("t2_idle_again", mem_req, 0);

    // Redirect while waiting on a slow response.
    do_reset();
    ready_prob = 100; lat_min = 3; lat_max = 3;
    run_until_reqs("t3_wait_timeout", 3);
    cycle(1, 30'h100);
    chk("t3_flushed", out_valid, 0);
    run_until_req("t3_req_timeout");
    chk("t3_new_addr", mem_addr, 30'h100);
    for (int k = 0; k < 30 && !out_valid; k++) cycle();
    chk("t3_new_head_pc", out_pc, 30'h100);
    chk("t3_new_head_instr", out_instr, TAG ^ 32'h100);

    // Redirect coinciding with the response.
    do_reset();
    ready_prob = 0; lat_min = 2; lat_max = 2;
    run_until_reqs("t4_wait_timeout", 2);
    for (int k = 0; k < 10 && !(pend && lat == 0); k++) cycle();
    chk("t4_resp_pending", pend && lat == 0, 1);
    cycle(1, 30'h40);
    chk("t4_empty", out_valid, 0);
    run_until_req("t4_req_timeout");
    chk("t4_new_addr", mem_addr, 30'h40);

    // Pointer wrap at the top of the address space.
    do_reset();
    ready_prob = 100; lat_min = 1; lat_max = 1;
    repeat (3) cycle();
    cycle(1, '1);
    req_log.delete();
    run_until_reqs("t5_timeout", 2);
    chk("t5_top_addr", req_at(0), 30'h3FFF_FFFF);
    chk("t5_wrap_addr", req_at(1), 0);

    // Reset while waiting with three words buffered.
    do_reset();
    ready_prob = 0; lat_min = 3; lat_max = 3;
    run_until_reqs("t6_timeout", 4);
    chk("t6_buffered", out_valid, 1);
    do_reset();
    stray = 1;
    cycle();
    chk("t6_req_after_rst", mem_req, 1);
    chk("t6_addr_after_rst", mem_addr, RST_ADDR);
    chk("t6_stray_dropped", out_valid, 0);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) begin
        gnt_prob   = $urandom_range(100, 30);
        ready_prob = $urandom_range(100, 0);
        lat_min    = $urandom_range(2, 1);
        lat_max    = lat_min + $urandom_range(2, 0);
      end
      if ($urandom_range(999) == 0) begin
        do_reset();
      end else if ($urandom_range(99) < 3) begin
        case ($urandom_range(3))
          0: ra = 30'h3FFF_FFFE;
          1: ra = 30'h3FFF_FFFF;
          2: ra = 30'($urandom_range(255));
          default: ra = 30'($urandom());
        endcase
        cycle(1, ra);
      end else begin
        cycle();
      end
    end
    compare_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
